// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: IF/ID and ID/EX instruction registers with bounded stalls and flush.
// Optional stall-cycle statistic counter built only when STALL_STATS_EN is defined.
module pipe_stall_ctrl #(
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter int          MAX_STALL = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction_IF,
    input  logic [15:0] pc_IF,
    input  logic        halt,
    input  logic        pc_enable,
    input  logic        flush,
    output logic [15:0] instruction_ID,
    output logic [15:0] pc_ID,
    output logic [15:0] instruction_EX,
    output logic        pc_write,
    output logic        stall_active,
    output logic        stall_error,
    output logic [15:0] stall_total
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_STALL);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic        w_set_err;
    logic        w_eff_halt;
    logic        w_bubble;
    logic        w_advance;
    logic [15:0] r_instr_id;
    logic [15:0] r_pc_id;
    logic [15:0] r_instr_ex;
    logic        r_stall_error;

    // A FORCE cycle ignores halt so the pipeline is guaranteed to make progress.
    assign w_eff_halt = halt && (r_state != S_FORCE);
    assign w_bubble   = w_eff_halt && !flush;
    assign w_advance  = !w_eff_halt && !flush;

    assign pc_write = (r_state == S_FORCE) || (pc_enable && !w_eff_halt && !flush) || flush;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_set_err    = 1'b0;
        if (flush) begin
            w_state_next = S_RUN;
            w_cnt_next   = 8'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_eff_halt) begin
                        w_state_next = S_STALL;
                        w_cnt_next   = 8'd1;
                    end
                end
                S_STALL: begin
                    if (!halt) begin
                        w_state_next = S_RUN;
                        w_cnt_next   = 8'd0;
                    end else if (r_cnt < MAX_CNT) begin
                        w_cnt_next   = r_cnt + 8'd1;
                    end else begin
                        w_state_next = S_FORCE;
                        w_cnt_next   = 8'd0;
                        w_set_err    = 1'b1;
                    end
                end
                S_FORCE: begin
                    w_state_next = S_RUN;
                    w_cnt_next   = 8'd0;
                end
                default: begin
                    w_state_next = S_RUN;
                    w_cnt_next   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_cnt         <= 8'd0;
            r_stall_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_stall_error <= r_stall_error || w_set_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_id <= NOP_INSTR;
            r_pc_id    <= 16'h0000;
            r_instr_ex <= NOP_INSTR;
        end else if (flush) begin
            r_instr_id <= NOP_INSTR;
            r_pc_id    <= 16'h0000;
            r_instr_ex <= NOP_INSTR;
        end else if (w_bubble) begin
            r_instr_ex <= NOP_INSTR;
        end else if (w_advance) begin
            r_instr_id <= instruction_IF;
            r_pc_id    <= pc_IF;
            r_instr_ex <= r_instr_id;
        end
    end

`ifdef STALL_STATS_EN
    logic [15:0] r_stall_total;

    // Saturating bubble counter; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_total <= 16'h0000;
        end else if (w_bubble && (r_stall_total != 16'hFFFF)) begin
            r_stall_total <= r_stall_total + 16'h0001;
        end
    end

    assign stall_total = r_stall_total;
`else
    assign stall_total = 16'h0000;
`endif

    assign instruction_ID = r_instr_id;
    assign pc_ID          = r_pc_id;
    assign instruction_EX = r_instr_ex;
    assign stall_active   = (r_state == S_STALL);
    assign stall_error    = r_stall_error;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: stimulus pushes expectations from a behavioural model,
// an independent monitor pops and compares each cycle.
module tb_pipe_stall_ctrl;

    localparam logic [15:0] NOP = 16'h0000;
    localparam int          MAXS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instruction_IF = 16'h0;
    logic [15:0] pc_IF = 16'h0;
    logic        halt = 1'b0;
    logic        pc_enable = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instruction_ID;
    logic [15:0] pc_ID;
    logic [15:0] instruction_EX;
    logic        pc_write;
    logic        stall_active;
    logic        stall_error;
    logic [15:0] stall_total;

    pipe_stall_ctrl #(.NOP_INSTR(NOP), .MAX_STALL(MAXS)) dut (
        .clk(clk), .rst(rst),
        .instruction_IF(instruction_IF), .pc_IF(pc_IF),
        .halt(halt), .pc_enable(pc_enable), .flush(flush),
        .instruction_ID(instruction_ID), .pc_ID(pc_ID), .instruction_EX(instruction_EX),
        .pc_write(pc_write), .stall_active(stall_active),
        .stall_error(stall_error), .stall_total(stall_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          txn;
        logic        pcw;
        logic [15:0] id;
        logic [15:0] pcid;
        logic [15:0] ex;
        logic        active;
        logic        err;
        logic [15:0] total;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn = 0;

    // Reference model: consecutive halted cycles spent stalled, plus a one-shot forced release.
    logic [15:0] m_id = NOP, m_pcid = 16'h0, m_ex = NOP, m_total = 16'h0;
    int          m_stall_cycles = 0;
    bit          m_forced = 1'b0;
    bit          m_err = 1'b0;

    task automatic cycle(input bit r, input bit fl, input bit h, input bit pe,
                         input logic [15:0] ins, input logic [15:0] pc);
        exp_t e;
        bit   eff_h;
        @(negedge clk);
        rst = r; flush = fl; halt = h; pc_enable = pe; instruction_IF = ins; pc_IF = pc;
        eff_h = h && !m_forced;
        e.txn = n_txn;
        e.pcw = m_forced || (pe && !eff_h && !fl) || fl;
        if (r) begin
            m_id = NOP; m_pcid = 16'h0; m_ex = NOP;
            m_stall_cycles = 0; m_forced = 0; m_err = 0; m_total = 16'h0;
        end else if (fl) begin
            m_id = NOP; m_pcid = 16'h0; m_ex = NOP;
            m_stall_cycles = 0; m_forced = 0;
        end else if (eff_h) begin
            m_ex = NOP;
            if (m_total != 16'hFFFF) m_total = m_total + 16'h1;
            if (m_stall_cycles == MAXS) begin
                m_stall_cycles = 0; m_forced = 1; m_err = 1;
            end else begin
                m_stall_cycles = m_stall_cycles + 1;
                m_forced = 0;
            end
        end else begin
            m_ex = m_id; m_id = ins; m_pcid = pc;
            m_stall_cycles = 0; m_forced = 0;
        end
        e.id = m_id; e.pcid = m_pcid; e.ex = m_ex;
        e.active = (m_stall_cycles != 0);
        e.err = m_err;
`ifdef STALL_STATS_EN
        e.total = m_total;
`else
        e.total = 16'h0;
`endif
        exp_q.push_back(e);
        n_txn++;
    endtask

    task automatic chk(input string name, input int txn, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL txn %0d %s: got %h expected %h", txn, name, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_write", e.txn, {15'h0, pc_write}, {15'h0, e.pcw});
                @(posedge clk);
                #1;
                chk("instruction_ID", e.txn, instruction_ID, e.id);
                chk("pc_ID", e.txn, pc_ID, e.pcid);
                chk("instruction_EX", e.txn, instruction_EX, e.ex);
                chk("stall_active", e.txn, {15'h0, stall_active}, {15'h0, e.active});
                chk("stall_error", e.txn, {15'h0, stall_error}, {15'h0, e.err});
                chk("stall_total", e.txn, stall_total, e.total);
                $display("txn %0d: ID=%h pcID=%h EX=%h pcw=%b act=%b err=%b tot=%0d",
                         e.txn, instruction_ID, pc_ID, instruction_EX, pc_write,
                         stall_active, stall_error, stall_total);
            end
        end
    end

    initial begin : stimulus
        int drain;
        // Reset, then single advance followed by one more edge.
        cycle(1, 0, 0, 1, 16'h0000, 16'h0000);
        cycle(0, 0, 0, 1, 16'hA43D, 16'h0010);
        cycle(0, 0, 0, 1, 16'h1111, 16'h0012);
        // Single-cycle stall with A53D in IF/ID.
        cycle(0, 0, 0, 1, 16'hA53D, 16'h0014);
        cycle(0, 0, 1, 1, 16'h2222, 16'h0016);
        cycle(0, 0, 0, 1, 16'h2222, 16'h0016);
        // Overrun: halt held until forced release, then back to run.
        for (int i = 0; i < MAXS + 3; i++) cycle(0, 0, 1, 1, 16'h3300 + 16'(i), 16'h0020);
        cycle(0, 0, 0, 1, 16'h3400, 16'h0022);
        // Flush together with halt.
        cycle(0, 0, 0, 1, 16'hB45E, 16'h0030);
        cycle(0, 1, 1, 1, 16'h4444, 16'h0032);
        cycle(0, 0, 0, 1, 16'h4545, 16'h0034);
        // Reset in the middle of a stall.
        cycle(0, 0, 1, 1, 16'h5555, 16'h0040);
        cycle(1, 0, 1, 1, 16'h5656, 16'h0042);
        cycle(0, 0, 0, 1, 16'h5757, 16'h0044);
        // Five single-cycle stalls from a clean statistic.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 1, 0, 16'h6000 + 16'(i), 16'h0050);
            cycle(0, 0, 0, 1, 16'h6100 + 16'(i), 16'h0052);
        end
        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 14) == 0),
                  ($urandom_range(0, 9) < 6), 1'($urandom), 16'($urandom), 16'($urandom));
        end
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
